// File: rtl/traffic_mon_pkg.sv
// Shared lamp encodings, direction/state/fault enumerations and small helpers
// for the four-way traffic conflict monitor.
package traffic_mon_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    typedef enum logic [1:0] {
        DIR_NORTH = 2'd0,
        DIR_SOUTH = 2'd1,
        DIR_EAST  = 2'd2,
        DIR_WEST  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_GREEN     = 3'd1,
        ST_YELLOW    = 3'd2,
        ST_ALLRED    = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE           = 3'd0,
        FC_ENCODING       = 3'd1,
        FC_CONFLICT       = 3'd2,
        FC_SEQUENCE       = 3'd3,
        FC_GREEN_TIME     = 3'd4,
        FC_YELLOW_TIME    = 3'd5,
        FC_ALLRED_TIMEOUT = 3'd6
    } fault_e;

    function automatic dir_e next_dir(input dir_e d);
        return dir_e'(d + 2'd1);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

endpackage

// File: rtl/light_decoder.sv
// Classifies one direction's 3-bit lamp code into green/yellow/red or invalid.
module light_decoder
    import traffic_mon_pkg::*;
(
    input  logic [2:0] lamp,
    output logic       is_green,
    output logic       is_yellow,
    output logic       is_red,
    output logic       invalid
);

    assign is_green  = (lamp == LAMP_GREEN);
    assign is_yellow = (lamp == LAMP_YELLOW);
    assign is_red    = (lamp == LAMP_RED);
    assign invalid   = ~(is_green | is_yellow | is_red);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Watches the four lamp heads of an N-S-E-W rotation, tracks phase timing and
// latches the first detected safety violation until reset.
module traffic_conflict_monitor
    import traffic_mon_pkg::*;
#(
    parameter int unsigned GREEN_MIN  = 9,
    parameter int unsigned GREEN_MAX  = 11,
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned YELLOW_MAX = 6,
    parameter int unsigned ALLRED_MAX = 2
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] north_dir,
    input  logic [2:0] south_dir,
    input  logic [2:0] east_dir,
    input  logic [2:0] west_dir,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] phase_dir,
    output logic [3:0] phase_secs,
    output logic [7:0] cycles,
    output logic       flash_red
);

    localparam logic [4:0] GREEN_MIN_L  = 5'(GREEN_MIN);
    localparam logic [4:0] GREEN_MAX_L  = 5'(GREEN_MAX);
    localparam logic [4:0] YELLOW_MIN_L = 5'(YELLOW_MIN);
    localparam logic [4:0] YELLOW_MAX_L = 5'(YELLOW_MAX);
    localparam logic [4:0] ALLRED_MAX_L = 5'(ALLRED_MAX);

    logic [2:0] lamp_s [4];
    logic [3:0] green_s;
    logic [3:0] yellow_s;
    logic [3:0] red_s;
    logic [3:0] invalid_s;

    assign lamp_s[0] = north_dir;
    assign lamp_s[1] = south_dir;
    assign lamp_s[2] = east_dir;
    assign lamp_s[3] = west_dir;

    for (genvar i = 0; i < 4; i++) begin : g_dec
        light_decoder u_dec (
            .lamp      (lamp_s[i]),
            .is_green  (green_s[i]),
            .is_yellow (yellow_s[i]),
            .is_red    (red_s[i]),
            .invalid   (invalid_s[i])
        );
    end

    state_e     state_r, state_n;
    dir_e       dir_r, dir_n;
    logic [3:0] secs_r, secs_n;
    logic [7:0] cycles_r, cycles_n;
    fault_e     code_r;
    logic       fault_r;
    logic       flash_r, flash_n;
    fault_e     phase_fault_s;
    fault_e     new_code_s;
    dir_e       green_dir_s;
    dir_e       nxt_s;

    // An invalid code is treated as non-red so it also counts towards conflicts.
    logic [3:0] nonred_s;
    logic [3:0] dir_oh_s;
    logic [3:0] nxt_oh_s;
    logic       conflict_s;
    logic       own_green_s;
    logic       own_yellow_s;
    logic       nxt_green_s;
    logic [4:0] secs_inc_s;

    assign nonred_s     = ~red_s;
    assign nxt_s        = next_dir(dir_r);
    assign dir_oh_s     = 4'b0001 << dir_r;
    assign nxt_oh_s     = 4'b0001 << nxt_s;
    assign conflict_s   = ((nonred_s & (nonred_s - 4'd1)) != 4'd0);
    assign own_green_s  = |(green_s & dir_oh_s);
    assign own_yellow_s = |(yellow_s & dir_oh_s);
    assign nxt_green_s  = |(green_s & nxt_oh_s);
    assign secs_inc_s   = {1'b0, secs_r} + 5'd1;

    // Direction of the green lamp used to lock on while waiting for sync.
    always_comb begin
        green_dir_s = DIR_NORTH;
        if (green_s[0]) begin
            green_dir_s = DIR_NORTH;
        end else if (green_s[1]) begin
            green_dir_s = DIR_SOUTH;
        end else if (green_s[2]) begin
            green_dir_s = DIR_EAST;
        end else if (green_s[3]) begin
            green_dir_s = DIR_WEST;
        end else begin
            green_dir_s = DIR_NORTH;
        end
    end

    // Phase sequencing and the per-phase timing/sequence checks.
    always_comb begin
        state_n       = state_r;
        dir_n         = dir_r;
        secs_n        = secs_r;
        cycles_n      = cycles_r;
        flash_n       = 1'b0;
        phase_fault_s = FC_NONE;
        case (state_r)
            ST_WAIT_SYNC: begin
                if (|green_s) begin
                    state_n = ST_GREEN;
                    dir_n   = green_dir_s;
                    secs_n  = 4'd0;
                end else begin
                    state_n = ST_WAIT_SYNC;
                end
            end
            ST_GREEN: begin
                if (own_green_s) begin
                    if (tick) begin
                        if (secs_inc_s > GREEN_MAX_L) begin
                            phase_fault_s = FC_GREEN_TIME;
                        end else begin
                            secs_n = sat_inc(secs_r);
                        end
                    end else begin
                        secs_n = secs_r;
                    end
                end else if (own_yellow_s) begin
                    if ({1'b0, secs_r} >= GREEN_MIN_L) begin
                        state_n = ST_YELLOW;
                        secs_n  = 4'd0;
                    end else begin
                        phase_fault_s = FC_GREEN_TIME;
                    end
                end else begin
                    phase_fault_s = FC_SEQUENCE;
                end
            end
            ST_YELLOW: begin
                if (own_yellow_s) begin
                    if (tick) begin
                        if (secs_inc_s > YELLOW_MAX_L) begin
                            phase_fault_s = FC_YELLOW_TIME;
                        end else begin
                            secs_n = sat_inc(secs_r);
                        end
                    end else begin
                        secs_n = secs_r;
                    end
                end else if (own_green_s) begin
                    phase_fault_s = FC_SEQUENCE;
                end else if ((|(nonred_s & ~dir_oh_s)) && !nxt_green_s) begin
                    phase_fault_s = FC_SEQUENCE;
                end else if ({1'b0, secs_r} < YELLOW_MIN_L) begin
                    phase_fault_s = FC_YELLOW_TIME;
                end else if (nxt_green_s) begin
                    state_n  = ST_GREEN;
                    dir_n    = nxt_s;
                    secs_n   = 4'd0;
                    cycles_n = (nxt_s == DIR_NORTH) ? cycles_r + 8'd1 : cycles_r;
                end else begin
                    state_n = ST_ALLRED;
                    secs_n  = 4'd0;
                end
            end
            ST_ALLRED: begin
                if (nonred_s == 4'd0) begin
                    if (tick) begin
                        if (secs_inc_s > ALLRED_MAX_L) begin
                            phase_fault_s = FC_ALLRED_TIMEOUT;
                        end else begin
                            secs_n = sat_inc(secs_r);
                        end
                    end else begin
                        secs_n = secs_r;
                    end
                end else if ((nonred_s == nxt_oh_s) && nxt_green_s) begin
                    state_n  = ST_GREEN;
                    dir_n    = nxt_s;
                    secs_n   = 4'd0;
                    cycles_n = (nxt_s == DIR_NORTH) ? cycles_r + 8'd1 : cycles_r;
                end else begin
                    phase_fault_s = FC_SEQUENCE;
                end
            end
            ST_FAULT: begin
                flash_n = tick ? ~flash_r : flash_r;
            end
            default: begin
                state_n = ST_WAIT_SYNC;
            end
        endcase
    end

    // Lowest fault code wins; encoding and conflict outrank every phase check.
    always_comb begin
        new_code_s = FC_NONE;
        if (state_r == ST_FAULT) begin
            new_code_s = FC_NONE;
        end else if (|invalid_s) begin
            new_code_s = FC_ENCODING;
        end else if (conflict_s) begin
            new_code_s = FC_CONFLICT;
        end else begin
            new_code_s = phase_fault_s;
        end
    end

    // State and output registers; a new fault freezes the phase bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_WAIT_SYNC;
            dir_r    <= DIR_NORTH;
            secs_r   <= 4'd0;
            cycles_r <= 8'd0;
            code_r   <= FC_NONE;
            fault_r  <= 1'b0;
            flash_r  <= 1'b0;
        end else if (new_code_s != FC_NONE) begin
            state_r <= ST_FAULT;
            code_r  <= new_code_s;
            fault_r <= 1'b1;
            flash_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            dir_r    <= dir_n;
            secs_r   <= secs_n;
            cycles_r <= cycles_n;
            flash_r  <= flash_n;
        end
    end

    assign fault      = fault_r;
    assign fault_code = code_r;
    assign phase_dir  = dir_r;
    assign phase_secs = secs_r;
    assign cycles     = cycles_r;
    assign flash_red  = flash_r;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench: directed scenarios plus randomized lamp sequences,
// compared against a rule-level reference model of the monitor.
module tb_traffic_conflict_monitor;

    localparam int GMIN = 9;
    localparam int GMAX = 11;
    localparam int YMIN = 3;
    localparam int YMAX = 6;
    localparam int AMAX = 2;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [2:0] north_dir, south_dir, east_dir, west_dir;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] phase_dir;
    logic [3:0] phase_secs;
    logic [7:0] cycles;
    logic       flash_red;
    logic [18:0] obs;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 wait, 1 green, 2 yellow, 3 all-red, 4 fault
    int m_st, m_dir, m_secs, m_cyc, m_code;
    logic m_fault, m_flash;

    traffic_conflict_monitor #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_MIN(YMIN),
        .YELLOW_MAX(YMAX), .ALLRED_MAX(AMAX)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .north_dir(north_dir), .south_dir(south_dir),
        .east_dir(east_dir), .west_dir(west_dir),
        .fault(fault), .fault_code(fault_code), .phase_dir(phase_dir),
        .phase_secs(phase_secs), .cycles(cycles), .flash_red(flash_red)
    );

    always #5 clk = ~clk;

    assign obs = {fault, fault_code, phase_dir, phase_secs, cycles, flash_red};

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_dir = 0; m_secs = 0; m_cyc = 0; m_code = 0;
        m_fault = 1'b0; m_flash = 1'b0;
    endfunction

    function automatic logic [18:0] model_vec();
        return {m_fault, 3'(m_code), 2'(m_dir), 4'(m_secs), 8'(m_cyc), m_flash};
    endfunction

    function automatic void model_step(input logic [2:0] n, input logic [2:0] s,
                                       input logic [2:0] e, input logic [2:0] w,
                                       input logic t);
        logic [2:0] l [4];
        int best, nonred, ngreen, gdir, nx, nst, ndir, nsecs, ncyc;
        l[0] = n; l[1] = s; l[2] = e; l[3] = w;
        if (m_st == 4) begin
            if (t) m_flash = ~m_flash;
            return;
        end
        best = 7; nonred = 0; ngreen = 0; gdir = 0;
        for (int i = 0; i < 4; i++) begin
            if (l[i] != G && l[i] != Y && l[i] != R) best = 1;
            if (l[i] != R) nonred++;
            if (l[i] == G) begin ngreen++; gdir = i; end
        end
        if (nonred > 1) best = mn(best, 2);
        nx = (m_dir + 1) % 4;
        nst = m_st; ndir = m_dir; nsecs = m_secs; ncyc = m_cyc;
        case (m_st)
            0: if (ngreen > 0) begin nst = 1; ndir = gdir; nsecs = 0; end
            1: begin
                if (l[m_dir] == G) begin
                    if (t) begin
                        if (m_secs + 1 > GMAX) best = mn(best, 4);
                        else nsecs = mn(m_secs + 1, 15);
                    end
                end else if (l[m_dir] == Y) begin
                    if (m_secs >= GMIN) begin nst = 2; nsecs = 0; end
                    else best = mn(best, 4);
                end else best = mn(best, 3);
            end
            2: begin
                if (l[m_dir] == Y) begin
                    if (t) begin
                        if (m_secs + 1 > YMAX) best = mn(best, 5);
                        else nsecs = mn(m_secs + 1, 15);
                    end
                end else if (l[m_dir] == G) best = mn(best, 3);
                else if (nonred > 0 && l[nx] != G) best = mn(best, 3);
                else if (m_secs < YMIN) best = mn(best, 5);
                else if (l[nx] == G) begin
                    nst = 1; ndir = nx; nsecs = 0;
                    if (nx == 0) ncyc = (m_cyc + 1) % 256;
                end else begin nst = 3; nsecs = 0; end
            end
            3: begin
                if (nonred == 0) begin
                    if (t) begin
                        if (m_secs + 1 > AMAX) best = mn(best, 6);
                        else nsecs = mn(m_secs + 1, 15);
                    end
                end else if (nonred == 1 && l[nx] == G) begin
                    nst = 1; ndir = nx; nsecs = 0;
                    if (nx == 0) ncyc = (m_cyc + 1) % 256;
                end else best = mn(best, 3);
            end
            default: ;
        endcase
        if (best < 7) begin
            m_st = 4; m_fault = 1'b1; m_code = best;
        end else begin
            m_st = nst; m_dir = ndir; m_secs = nsecs; m_cyc = ncyc;
        end
    endfunction

    task automatic drive(input logic [2:0] n, input logic [2:0] s,
                         input logic [2:0] e, input logic [2:0] w, input logic t);
        north_dir = n; south_dir = s; east_dir = e; west_dir = w; tick = t;
        @(posedge clk);
        model_step(n, s, e, w, t);
        #1;
    endtask

    task automatic set_one(input int d, input logic [2:0] lamp, input logic t);
        logic [2:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = (i == d) ? lamp : R;
        drive(l[0], l[1], l[2], l[3], t);
    endtask

    task automatic hold(input int d, input logic [2:0] lamp, input int n);
        for (int k = 0; k < n; k++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) set_one(d, lamp, 1'b0);
            set_one(d, lamp, 1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0;
        north_dir = R; south_dir = R; east_dir = R; west_dir = R;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 19'd0) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs, 19'd0);
        end
        set_one(2, G, 1'b1);
        checks++;
        if (phase_dir !== 2'd2 || fault !== 1'b0 || phase_secs !== 4'd0) begin
            failures++; $display("FAIL first_edge_after_reset got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_legal_loop();
        do_reset();
        set_one(0, G, 1'($urandom_range(0, 1)));
        for (int p = 0; p < 12; p++) begin
            int d;
            d = p % 4;
            hold(d, G, 10);
            checks++;
            if (phase_secs !== 4'd10 || obs !== model_vec()) begin
                failures++; $display("FAIL loop_green_peak p=%0d got=%h exp_secs=10 model=%h", p, obs, model_vec());
            end
            set_one(d, Y, 1'($urandom_range(0, 1)));
            hold(d, Y, 5);
            checks++;
            if (phase_secs !== 4'd5 || obs !== model_vec()) begin
                failures++; $display("FAIL loop_yellow_peak p=%0d got=%h exp_secs=5 model=%h", p, obs, model_vec());
            end
            set_one((d + 1) % 4, G, 1'($urandom_range(0, 1)));
            checks++;
            if (phase_secs !== 4'd0 || phase_dir !== 2'((d + 1) % 4)) begin
                failures++; $display("FAIL loop_phase_change p=%0d got=%h exp=%h", p, obs, model_vec());
            end
        end
        checks++;
        if (fault !== 1'b0 || cycles !== 8'd3) begin
            failures++; $display("FAIL loop_final fault=%0d cycles=%0d exp fault=0 cycles=3", fault, cycles);
        end
    endtask

    task automatic test_encoding();
        logic exp_flash;
        do_reset();
        set_one(0, G, 1'b0);
        hold(0, G, 3);
        drive(3'b011, R, R, R, 1'b0);
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || phase_secs !== 4'd3) begin
            failures++; $display("FAIL encoding got=%h exp fault=1 code=1 secs=3", obs);
        end
        exp_flash = 1'b0;
        for (int k = 0; k < 10; k++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            set_one(0, G, t);
            exp_flash = exp_flash ^ t;
            checks++;
            if (flash_red !== exp_flash || fault_code !== 3'd1 || fault !== 1'b1) begin
                failures++; $display("FAIL flash_toggle k=%0d flash=%0d exp=%0d code=%0d", k, flash_red, exp_flash, fault_code);
            end
        end
    endtask

    task automatic test_conflict_sequence();
        do_reset();
        set_one(0, G, 1'b0);
        drive(G, R, Y, R, 1'b0);
        checks++;
        if (fault_code !== 3'd2 || fault !== 1'b1) begin
            failures++; $display("FAIL conflict got_code=%0d exp=2", fault_code);
        end
        do_reset();
        set_one(1, G, 1'b0); hold(1, G, 9); set_one(1, Y, 1'b0); hold(1, Y, 3);
        drive(R, R, R, G, 1'b0);
        checks++;
        if (fault_code !== 3'd3 || obs !== model_vec()) begin
            failures++; $display("FAIL sequence_skip got=%h exp_code=3 model=%h", obs, model_vec());
        end
        do_reset();
        set_one(1, G, 1'b0); hold(1, G, 9); set_one(1, Y, 1'b0); hold(1, Y, 3);
        drive(R, R, G, R, 1'b1);
        checks++;
        if (fault !== 1'b0 || phase_dir !== 2'd2 || phase_secs !== 4'd0) begin
            failures++; $display("FAIL direct_next_green got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_timing();
        do_reset();
        set_one(2, G, 1'b0); hold(2, G, 8); set_one(2, Y, 1'b0);
        checks++;
        if (fault_code !== 3'd4) begin
            failures++; $display("FAIL green_short got_code=%0d exp=4", fault_code);
        end
        do_reset();
        set_one(2, G, 1'b0); hold(2, G, 10); set_one(2, Y, 1'b0); hold(2, Y, 7);
        checks++;
        if (fault_code !== 3'd5 || obs !== model_vec()) begin
            failures++; $display("FAIL yellow_long got=%h exp_code=5 model=%h", obs, model_vec());
        end
        do_reset();
        set_one(2, G, 1'b0); hold(2, G, 10); set_one(2, Y, 1'b0); hold(2, Y, 4);
        set_one(2, R, 1'b0); hold(2, R, 2);
        checks++;
        if (fault !== 1'b0 || phase_secs !== 4'd2) begin
            failures++; $display("FAIL allred_legal got=%h exp=%h", obs, model_vec());
        end
        hold(2, R, 1);
        checks++;
        if (fault_code !== 3'd6) begin
            failures++; $display("FAIL allred_timeout got_code=%0d exp=6", fault_code);
        end
        do_reset();
        set_one(0, G, 1'b0); hold(0, G, 12);
        checks++;
        if (fault_code !== 3'd4) begin
            failures++; $display("FAIL green_long got_code=%0d exp=4", fault_code);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_one(2, G, 1'b0); hold(2, G, 10); set_one(2, Y, 1'b0); hold(2, Y, 2);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 19'd0) begin
            failures++; $display("FAIL reset_mid_yellow got=%h exp=%h", obs, 19'd0);
        end
        reset = 1'b0;
        model_reset();
        set_one(3, G, 1'b0);
        checks++;
        if (fault !== 1'b0 || phase_dir !== 2'd3 || obs !== model_vec()) begin
            failures++; $display("FAIL resync_after_yellow got=%h exp=%h", obs, model_vec());
        end
        drive(3'b111, R, R, G, 1'b0);
        hold(3, G, 3);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 19'd0) begin
            failures++; $display("FAIL reset_mid_fault got=%h exp=%h", obs, 19'd0);
        end
        reset = 1'b0;
        model_reset();
        set_one(1, G, 1'b1);
        checks++;
        if (fault !== 1'b0 || phase_dir !== 2'd1 || phase_secs !== 4'd0) begin
            failures++; $display("FAIL resync_after_fault got=%h exp=%h", obs, model_vec());
        end
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 5; ep++) begin
            int d, seg, rem;
            do_reset();
            d = $urandom_range(0, 3); seg = 0; rem = $urandom_range(7, 11);
            for (int c = 0; c < 250; c++) begin
                logic [2:0] l [4];
                logic t;
                t = 1'($urandom_range(0, 1));
                for (int i = 0; i < 4; i++) l[i] = R;
                l[d] = (seg == 0) ? G : ((seg == 1) ? Y : R);
                if ($urandom_range(0, 59) == 0) begin
                    int ci;
                    ci = $urandom_range(0, 3);
                    l[ci] = 3'($urandom_range(0, 7));
                end
                drive(l[0], l[1], l[2], l[3], t);
                checks++;
                if (obs !== model_vec()) begin
                    failures++; $display("FAIL random ep=%0d cyc=%0d got=%h exp=%h", ep, c, obs, model_vec());
                end
                if (t) begin
                    if (rem > 0) rem--;
                    else if (seg == 0) begin seg = 1; rem = $urandom_range(1, 6); end
                    else if (seg == 1) begin
                        rem = $urandom_range(0, 3);
                        if (rem == 0) begin d = (d + 1) % 4; seg = 0; rem = $urandom_range(7, 11); end
                        else begin seg = 2; rem = rem - 1; end
                    end else begin
                        d = (d + 1) % 4; seg = 0; rem = $urandom_range(7, 11);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 1'b0;
        north_dir = R; south_dir = R; east_dir = R; west_dir = R;
        model_reset();
        test_reset();
        test_legal_loop();
        test_encoding();
        test_conflict_sequence();
        test_timing();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
